// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit slice.
package lsu_pkg;

    localparam int unsigned LSU_ADDR_W = 6;
    localparam int unsigned LSU_DATA_W = 32;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        SB  = 3'd3,
        LBU = 3'd4,
        LHU = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RSP
    } lsu_state_t;

    // Big-endian half-word lane offsets within a word.
    localparam logic [1:0] HALF_HI_OFF = 2'd0;
    localparam logic [1:0] HALF_LO_OFF = 2'd2;

    function automatic logic is_store(input lsu_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Byte accesses are always aligned; unknown encodings report as misaligned.
    function automatic logic is_aligned(input lsu_op_t op, input logic [1:0] off);
        case (op)
            LB, LBU, SB: return 1'b1;
            LH, LHU, SH: return (off[0] == 1'b0);
            LW, SW:      return (off == 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between execute (master) and the LSU (slave).
interface lsu_if;
    import lsu_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    lsu_op_t               req_op;
    logic [LSU_ADDR_W-1:0] req_addr;
    logic [LSU_DATA_W-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [LSU_DATA_W-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_lane.sv
// Big-endian lane logic: load extract/extend and sub-word store merge.
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane, extend for loads, splice for stores.
    always_comb begin
        case (off)
            2'd0:    byte_v = word[31:24];
            2'd1:    byte_v = word[23:16];
            2'd2:    byte_v = word[15:8];
            default: byte_v = word[7:0];
        endcase
        half_v = (off[1] == HALF_LO_OFF[1]) ? word[15:0] : word[31:16];

        case (op)
            LB:      load_data = {{24{byte_v[7]}}, byte_v};
            LBU:     load_data = {24'd0, byte_v};
            LH:      load_data = {{16{half_v[15]}}, half_v};
            LHU:     load_data = {16'd0, half_v};
            default: load_data = word;
        endcase

        merged = word;
        case (op)
            SB: begin
                case (off)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            SH: begin
                if (off[1] == HALF_LO_OFF[1]) merged[15:0]  = wdata[15:0];
                else                          merged[31:16] = wdata[15:0];
            end
            SW:      merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store front end driving data_mem's word port.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = LSU_ADDR_W,
    parameter int unsigned DATA_W = LSU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_if.slave              bus,
    output logic              mem_Wen,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_t        state_q, state_d;
    logic              accept;
    lsu_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and request acceptance.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (!is_aligned(bus.req_op, bus.req_addr[1:0])) state_d = RSP;
                    else if (bus.req_op == SW)                      state_d = WR;
                    else                                            state_d = RD;
                end
            end
            RD:      state_d = is_store(op_q) ? WR : RSP;
            WR:      state_d = RSP;
            RSP:     if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, read-word capture and response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= LB;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= bus.req_op;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= !is_aligned(bus.req_op, bus.req_addr[1:0]);
        end else if (state_q == RD) begin
            word_q <= mem_read_data;
            if (!is_store(op_q)) rdata_q <= load_data;
        end
    end

    // Loads extract straight from the read port in RD; merges work on the captured word.
    assign lane_word = (state_q == RD) ? mem_read_data : word_q;

    lsu_lane u_lane (
        .op        (op_q),
        .off       (addr_q[1:0]),
        .word      (lane_word),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.rsp_valid  = (state_q == RSP);
    assign bus.rsp_rdata  = rdata_q;
    assign bus.rsp_err    = err_q;
    assign mem_Wen        = (state_q == WR);
    assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_write_data = merged;

endmodule
